sofm_dist_engine: RTL and testbench

Parametrised multi-neuron distance engine for the SOFM winner search. It streams one input-vector element per beat against NEURONS weight elements in parallel. It accumulates an L1 or squared-L2 distance per neuron over DIM beats, then runs a sequential argmin over the lanes. The winner index and per-neuron distances are presented on a valid/ready output to the weight-update stage. It replaces the single-lane, fixed-width L1 accumulator.

---
 rtl/sofm_pkg.sv | 32 +++
 rtl/sofm_dist_lane.sv | 48 ++++
 rtl/sofm_dist_engine.sv | 183 ++++++++++++++++++
 tb/tb_sofm_dist_engine.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sofm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sofm_pkg
// Description : Shared types and sizing helpers for the SOFM winner-search
//               distance engine and the weight-update stage.
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
package sofm_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } sofm_state_t;

  localparam logic MODE_L1 = 1'b0;
  localparam logic MODE_L2 = 1'b1;

  // Accumulator width that cannot overflow for a DIM-long sum of squared
  // DATA_W-bit differences.
  function automatic int sofm_acc_w(input int data_w, input int dim);
    return 2 * data_w + $clog2(dim);
  endfunction

  // Winner index width; a single lane still needs one bit.
  function automatic int sofm_idx_w(input int neurons);
    return (neurons > 1) ? $clog2(neurons) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sofm_dist_lane.sv
`default_nettype none
// ============================================================================
// Module      : sofm_dist_lane
// Description : One neuron lane: absolute difference, optional square, and
//               the distance accumulator with load/add enables.
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
module sofm_dist_lane
  import sofm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_w,
  input  logic              i_mode,
  input  logic              i_load,
  input  logic              i_add,
  output logic [ACC_W-1:0]  o_acc
);

  logic [DATA_W-1:0]   w_diff;
  logic [2*DATA_W-1:0] w_sq;
  logic [ACC_W-1:0]    w_term;
  logic [ACC_W-1:0]    r_acc;

  assign w_diff = (i_w >= i_x) ? (i_w - i_x) : (i_x - i_w);
  assign w_sq   = {{DATA_W{1'b0}}, w_diff} * {{DATA_W{1'b0}}, w_diff};
  assign w_term = (i_mode == MODE_L2) ? {{(ACC_W-2*DATA_W){1'b0}}, w_sq}
                                      : {{(ACC_W-DATA_W){1'b0}}, w_diff};

  // First beat of a vector overwrites the accumulator, later beats add.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_term;
    end else if (i_add) begin
      r_acc <= r_acc + w_term;
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/sofm_dist_engine.sv
`default_nettype none
// ============================================================================
// Module      : sofm_dist_engine
// Description : Streams one input element per beat against NEURONS weight
//               lanes, accumulates L1 or squared-L2 distances, then scans the
//               lanes sequentially for the minimum and presents the result on
//               a valid/ready interface.
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
module sofm_dist_engine
  import sofm_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DIM     = 16,
  parameter int NEURONS = 4,
  parameter int IDX_W   = sofm_idx_w(NEURONS),
  parameter int ACC_W   = sofm_acc_w(DATA_W, DIM)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clear,
  input  logic                      i_mode,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [DATA_W-1:0]         i_x,
  input  logic [NEURONS*DATA_W-1:0] i_w,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [NEURONS*ACC_W-1:0]  o_dist,
  output logic [IDX_W-1:0]          o_win_idx,
  output logic [ACC_W-1:0]          o_min_dist
);

  localparam int               CNT_W       = $clog2(DIM);
  localparam logic [CNT_W-1:0] C_LAST_ELEM = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_LAST_LANE = IDX_W'(NEURONS - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE   = IDX_W'(1);

  sofm_state_t              r_state;
  logic                     r_mode;
  logic                     r_ready;
  logic                     r_valid;
  logic [CNT_W-1:0]         r_elem_cnt;
  logic [IDX_W-1:0]         r_cmp_idx;
  logic [IDX_W-1:0]         r_best_idx;
  logic [ACC_W-1:0]         r_best;
  logic [NEURONS*ACC_W-1:0] r_dist;
  logic [IDX_W-1:0]         r_win_idx;
  logic [ACC_W-1:0]         r_min_dist;

  logic                     w_accept;
  logic                     w_result_hs;
  logic                     w_lane_mode;
  logic                     w_load;
  logic                     w_add;
  logic                     w_last_lane;
  logic                     w_take;
  logic [ACC_W-1:0]         w_cmp_val;
  logic [ACC_W-1:0]         w_acc [NEURONS];

  assign w_accept    = r_ready & i_valid;
  assign w_result_hs = r_valid & i_ready;
  // The first beat uses the live mode; the rest of the vector uses the latch.
  assign w_lane_mode = (r_state == S_IDLE) ? i_mode : r_mode;
  assign w_load      = w_accept & ~i_clear & (r_state == S_IDLE);
  assign w_add       = w_accept & ~i_clear & (r_state == S_ACCUM);
  assign w_cmp_val   = w_acc[r_cmp_idx];
  assign w_last_lane = (r_cmp_idx == C_LAST_LANE);
  // Lane 0 seeds the search; afterwards only a strictly smaller value wins,
  // so ties stay with the lower index.
  assign w_take      = (r_cmp_idx == '0) || (w_cmp_val < r_best);

  generate
    for (genvar k = 0; k < NEURONS; k++) begin : g_lane
      sofm_dist_lane #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_lane (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_x     (i_x),
        .i_w     (i_w[k*DATA_W +: DATA_W]),
        .i_mode  (w_lane_mode),
        .i_load  (w_load),
        .i_add   (w_add),
        .o_acc   (w_acc[k])
      );
    end
  endgenerate

  // Control FSM: state, element/compare counters, latched mode, ready/valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= MODE_L1;
      r_elem_cnt <= '0;
      r_cmp_idx  <= '0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
    end else if (i_clear) begin
      r_state    <= S_IDLE;
      r_elem_cnt <= '0;
      r_cmp_idx  <= '0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode     <= i_mode;
            r_elem_cnt <= C_CNT_ONE;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            if (r_elem_cnt == C_LAST_ELEM) begin
              r_elem_cnt <= '0;
              r_cmp_idx  <= '0;
              r_ready    <= 1'b0;
              r_state    <= S_COMPARE;
            end else begin
              r_elem_cnt <= r_elem_cnt + C_CNT_ONE;
            end
          end
        end
        S_COMPARE: begin
          if (w_last_lane) begin
            r_cmp_idx <= '0;
            r_valid   <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cmp_idx <= r_cmp_idx + C_IDX_ONE;
          end
        end
        S_DONE: begin
          if (w_result_hs) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Running argmin during COMPARE; the result registers load on the last lane.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_best     <= '0;
      r_best_idx <= '0;
      r_dist     <= '0;
      r_win_idx  <= '0;
      r_min_dist <= '0;
    end else if (!i_clear && (r_state == S_COMPARE)) begin
      if (w_take) begin
        r_best     <= w_cmp_val;
        r_best_idx <= r_cmp_idx;
      end
      if (w_last_lane) begin
        r_min_dist <= w_take ? w_cmp_val : r_best;
        r_win_idx  <= w_take ? r_cmp_idx : r_best_idx;
        for (int k = 0; k < NEURONS; k++) begin
          r_dist[k*ACC_W +: ACC_W] <= w_acc[k];
        end
      end
    end
  end

  assign o_ready    = r_ready;
  assign o_valid    = r_valid;
  assign o_dist     = r_dist;
  assign o_win_idx  = r_win_idx;
  assign o_min_dist = r_min_dist;

endmodule
`default_nettype wire

// File: tb/tb_sofm_dist_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sofm_dist_engine
// Description : Self-checking bench for sofm_dist_engine; expected distances
//               and winners come from a plain-arithmetic vector model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sofm_dist_engine;

  localparam int DATA_W  = 8;
  localparam int DIM     = 16;
  localparam int NEURONS = 4;
  localparam int ACC_W   = 20;
  localparam int IDX_W   = 2;

  logic                      i_clk   = 1'b0;
  logic                      i_rst_n = 1'b0;
  logic                      i_clear = 1'b0;
  logic                      i_mode  = 1'b0;
  logic                      i_valid = 1'b0;
  logic                      i_ready = 1'b0;
  logic [DATA_W-1:0]         i_x     = '0;
  logic [NEURONS*DATA_W-1:0] i_w     = '0;
  logic                      o_ready;
  logic                      o_valid;
  logic [NEURONS*ACC_W-1:0]  o_dist;
  logic [IDX_W-1:0]          o_win_idx;
  logic [ACC_W-1:0]          o_min_dist;

  int checks = 0;
  int errors = 0;

  int unsigned              xs [DIM];
  int unsigned              ws [NEURONS][DIM];
  bit                       modes [DIM];
  int                       exp_dist [NEURONS];
  int                       exp_idx;
  int                       exp_min;
  logic [NEURONS*ACC_W-1:0] exp_pack;
  logic [NEURONS*ACC_W-1:0] prev_pack;

  sofm_dist_engine #(
    .DATA_W  (DATA_W),
    .DIM     (DIM),
    .NEURONS (NEURONS)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (i_clear),
    .i_mode     (i_mode),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_x        (i_x),
    .i_w        (i_w),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_dist     (o_dist),
    .o_win_idx  (o_win_idx),
    .o_min_dist (o_min_dist)
  );

  always #5 i_clk = ~i_clk;

  // Reference: distance is the sum over the vector of |w-x| or (w-x)^2 using
  // the mode of the first element; winner is the first lane holding the minimum.
  task automatic model();
    int s;
    int d;
    for (int k = 0; k < NEURONS; k++) begin
      s = 0;
      for (int e = 0; e < DIM; e++) begin
        d = int'(ws[k][e]) - int'(xs[e]);
        if (d < 0) d = -d;
        s = s + (modes[0] ? d * d : d);
      end
      exp_dist[k] = s;
      exp_pack[k*ACC_W +: ACC_W] = ACC_W'(s);
    end
    exp_idx = 0;
    exp_min = exp_dist[0];
    for (int k = 1; k < NEURONS; k++) begin
      if (exp_dist[k] < exp_min) begin
        exp_min = exp_dist[k];
        exp_idx = k;
      end
    end
  endtask

  task automatic fill_const(input int xv, input int w0, input int w1,
                            input int w2, input int w3, input bit m);
    for (int e = 0; e < DIM; e++) begin
      xs[e] = xv; ws[0][e] = w0; ws[1][e] = w1; ws[2][e] = w2; ws[3][e] = w3;
      modes[e] = m;
    end
  endtask

  task automatic fill_random(input bit m, input bit toggle);
    for (int e = 0; e < DIM; e++) begin
      xs[e] = $urandom_range(0, 255);
      for (int k = 0; k < NEURONS; k++) ws[k][e] = $urandom_range(0, 255);
      modes[e] = toggle ? (m ^ e[0]) : m;
    end
  endtask

  // Presents elements 0..n-1; idle beats carry junk data and junk mode.
  task automatic drive_beats(input int n, input int throttle, output int cycles);
    int e;
    bit v;
    bit acc;
    e = 0;
    cycles = 0;
    while (e < n && cycles < 400) begin
      v = ($urandom_range(0, 99) >= throttle);
      i_valid = v;
      i_x     = v ? xs[e][DATA_W-1:0] : DATA_W'($urandom);
      i_mode  = v ? modes[e] : 1'($urandom);
      for (int k = 0; k < NEURONS; k++)
        i_w[k*DATA_W +: DATA_W] = v ? ws[k][e][DATA_W-1:0] : DATA_W'($urandom);
      acc = v && o_ready;
      @(posedge i_clk); #1;
      if (acc) e++;
      cycles++;
    end
    i_valid = 1'b0;
  endtask

  // Counts edges after the last accept until o_valid; -1 when it never comes.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
    if (!o_valid) lat = -1;
  endtask

  task automatic take_result();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_dist !== '0 || o_win_idx !== '0 || o_min_dist !== '0) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b dist=%h idx=%0d min=%0d required 1 0 0 0 0",
               o_ready, o_valid, o_dist, o_win_idx, o_min_dist);
    end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_l1();
    int cyc, lat;
    fill_const(10, 10, 12, 7, 200, 1'b0);
    model();
    drive_beats(DIM, 0, cyc);
    wait_valid(lat);
    checks++;
    if (lat !== NEURONS) begin errors++; $display("FAIL l1_latency: got %0d required %0d", lat, NEURONS); end
    checks++;
    if (o_dist !== exp_pack) begin errors++; $display("FAIL l1_dist: got %h required %h", o_dist, exp_pack); end
    checks++;
    if (o_win_idx !== IDX_W'(exp_idx) || o_min_dist !== ACC_W'(exp_min)) begin
      errors++; $display("FAIL l1_win: got %0d/%0d required %0d/%0d", o_win_idx, o_min_dist, exp_idx, exp_min);
    end
    take_result();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL l1_handshake: got rdy=%b vld=%b required 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_l2(input int xv, input int w0, input int w1, input int w2, input int w3, input string nm);
    int cyc, lat;
    fill_const(xv, w0, w1, w2, w3, 1'b1);
    model();
    drive_beats(DIM, 0, cyc);
    wait_valid(lat);
    checks++;
    if (o_dist !== exp_pack) begin errors++; $display("FAIL %s_dist: got %h required %h", nm, o_dist, exp_pack); end
    checks++;
    if (o_win_idx !== IDX_W'(exp_idx) || o_min_dist !== ACC_W'(exp_min) || lat !== NEURONS) begin
      errors++; $display("FAIL %s_win: got %0d/%0d lat %0d required %0d/%0d lat %0d",
                         nm, o_win_idx, o_min_dist, lat, exp_idx, exp_min, NEURONS);
    end
    take_result();
  endtask

  task automatic test_tie_throttle();
    int cyc, lat;
    fill_const(0, 0, 0, 0, 0, 1'b0);
    ws[0][0] = 6; ws[1][0] = 5; ws[2][3] = 9; ws[3][DIM-1] = 5;
    model();
    drive_beats(DIM, 50, cyc);
    wait_valid(lat);
    checks++;
    if (o_win_idx !== 2'd1 || o_min_dist !== ACC_W'(5)) begin
      errors++; $display("FAIL tie_win: got %0d/%0d required 1/5", o_win_idx, o_min_dist);
    end
    checks++;
    if (o_dist !== exp_pack || lat !== NEURONS) begin
      errors++; $display("FAIL tie_dist: got %h lat %0d required %h lat %0d", o_dist, lat, exp_pack, NEURONS);
    end
    take_result();
  endtask

  task automatic test_hold_back_to_back();
    int cyc, lat;
    fill_random(1'b0, 1'b0);
    model();
    drive_beats(DIM, 0, cyc);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_dist !== exp_pack || o_win_idx !== IDX_W'(exp_idx)) begin
        errors++; $display("FAIL hold_stable cycle %0d: got vld=%b rdy=%b dist=%h idx=%0d required 1 0 %h %0d",
                           i, o_valid, o_ready, o_dist, o_win_idx, exp_pack, exp_idx);
      end
    end
    take_result();
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", o_ready); end
    fill_random(1'b1, 1'b0);
    model();
    drive_beats(DIM, 0, cyc);
    checks++;
    if (cyc !== DIM) begin errors++; $display("FAIL b2b_cycles: got %0d required %0d", cyc, DIM); end
    wait_valid(lat);
    checks++;
    if (o_dist !== exp_pack || o_win_idx !== IDX_W'(exp_idx) || lat !== NEURONS) begin
      errors++; $display("FAIL b2b_result: got %h/%0d lat %0d required %h/%0d lat %0d",
                         o_dist, o_win_idx, lat, exp_pack, exp_idx, NEURONS);
    end
    prev_pack = exp_pack;
    take_result();
  endtask

  task automatic test_clear_accum();
    int cyc, lat;
    fill_random(1'b1, 1'b0);
    drive_beats(7, 0, cyc);
    i_valid = 1'b1; i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_clear = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_dist !== prev_pack) begin
      errors++; $display("FAIL clear_accum_state: got rdy=%b vld=%b dist=%h required 1 0 %h",
                         o_ready, o_valid, o_dist, prev_pack);
    end
    fill_random(1'b0, 1'b0);
    model();
    drive_beats(DIM, 20, cyc);
    wait_valid(lat);
    checks++;
    if (o_dist !== exp_pack || o_win_idx !== IDX_W'(exp_idx) || o_min_dist !== ACC_W'(exp_min)) begin
      errors++; $display("FAIL clear_accum_result: got %h/%0d/%0d required %h/%0d/%0d",
                         o_dist, o_win_idx, o_min_dist, exp_pack, exp_idx, exp_min);
    end
    prev_pack = exp_pack;
    take_result();
  endtask

  task automatic test_clear_compare();
    int cyc, lat, seen;
    fill_random(1'b1, 1'b0);
    drive_beats(DIM, 0, cyc);
    @(posedge i_clk); #1;
    i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid) seen++;
      @(posedge i_clk); #1;
    end
    checks++;
    if (seen !== 0 || o_ready !== 1'b1 || o_dist !== prev_pack) begin
      errors++; $display("FAIL clear_compare_state: got vld_cycles=%0d rdy=%b dist=%h required 0 1 %h",
                         seen, o_ready, o_dist, prev_pack);
    end
    fill_random(1'b1, 1'b0);
    model();
    drive_beats(DIM, 0, cyc);
    wait_valid(lat);
    checks++;
    if (o_dist !== exp_pack || o_win_idx !== IDX_W'(exp_idx) || lat !== NEURONS) begin
      errors++; $display("FAIL clear_compare_result: got %h/%0d lat %0d required %h/%0d lat %0d",
                         o_dist, o_win_idx, lat, exp_pack, exp_idx, NEURONS);
    end
    take_result();
  endtask

  task automatic test_async_reset();
    int cyc, lat;
    fill_random(1'b0, 1'b0);
    drive_beats(8, 0, cyc);
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_dist !== '0 || o_win_idx !== '0 || o_min_dist !== '0) begin
      errors++; $display("FAIL async_reset: got rdy=%b vld=%b dist=%h idx=%0d min=%0d required 1 0 0 0 0",
                         o_ready, o_valid, o_dist, o_win_idx, o_min_dist);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    fill_random(1'b0, 1'b0);
    model();
    drive_beats(DIM, 0, cyc);
    wait_valid(lat);
    checks++;
    if (o_dist !== exp_pack || o_win_idx !== IDX_W'(exp_idx)) begin
      errors++; $display("FAIL after_reset_result: got %h/%0d required %h/%0d", o_dist, o_win_idx, exp_pack, exp_idx);
    end
    take_result();
  endtask

  task automatic test_mode_toggle();
    int cyc, lat;
    for (int m = 0; m < 2; m++) begin
      fill_random(m[0], 1'b1);
      model();
      drive_beats(DIM, 30, cyc);
      wait_valid(lat);
      checks++;
      if (o_dist !== exp_pack || o_win_idx !== IDX_W'(exp_idx) || o_min_dist !== ACC_W'(exp_min)) begin
        errors++; $display("FAIL mode_toggle m%0d: got %h/%0d/%0d required %h/%0d/%0d",
                           m, o_dist, o_win_idx, o_min_dist, exp_pack, exp_idx, exp_min);
      end
      take_result();
    end
  endtask

  task automatic test_random();
    int cyc, lat;
    for (int n = 0; n < 8; n++) begin
      fill_random(1'($urandom), 1'b0);
      model();
      drive_beats(DIM, $urandom_range(0, 60), cyc);
      wait_valid(lat);
      repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
      checks++;
      if (o_dist !== exp_pack || o_win_idx !== IDX_W'(exp_idx) || o_min_dist !== ACC_W'(exp_min) || lat !== NEURONS) begin
        errors++; $display("FAIL random %0d: got %h/%0d/%0d lat %0d required %h/%0d/%0d lat %0d",
                           n, o_dist, o_win_idx, o_min_dist, lat, exp_pack, exp_idx, exp_min, NEURONS);
      end
      take_result();
    end
  endtask

  initial begin
    prev_pack = '0;
    test_reset();
    test_l1();
    test_l2(10, 10, 12, 7, 200, "l2");
    test_l2(0, 255, 255, 255, 255, "l2_max");
    test_tie_throttle();
    test_hold_back_to_back();
    test_clear_accum();
    test_clear_compare();
    test_tie_throttle();
    test_async_reset();
    test_mode_toggle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
